// File: rtl/seq_1010_tx.sv
// rtl/seq_1010_tx.sv - framed serial transmitter: 1010 marker then bit-stuffed payload
//
// Purpose: accepts a DATA_W-bit payload over valid/ready and sends it as a frame:
// the 1010 sync marker, then the payload MSB-first.
// A 1 is stuffed after every 1,0,1 seen in the payload region, so a
// non-overlapping 1010 detector on the line fires only on the marker.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset (lands in GAP)
//   data_in     payload word, sampled on accept
//   valid_in    payload available (only looked at in IDLE)
//   ready_out   high only in IDLE
//   x_out       serial line bit, 0 whenever x_en is 0
//   x_en        high for marker, payload and stuffed bits
//   frame_done  one-cycle pulse on the first GAP cycle after a frame
//   stuff_cnt   stuffed bits in the current or last frame
module seq_1010_tx #(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic                          x_out,
  output logic                          x_en,
  output logic                          frame_done,
  output logic [$clog2(DATA_W+1)-1:0]   stuff_cnt
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int GW = $clog2(IDLE_GAP);

  typedef enum logic [2:0] {IDLE, PRE, DATA, STUFF, GAP} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;    // remaining payload, MSB is the next bit out
  logic [CW-1:0]     dcnt;     // payload bits already emitted
  logic [2:0]        hist;     // last three bits emitted in the payload region
  logic [1:0]        pre_cnt;  // index of the marker bit currently on the line
  logic [GW-1:0]     gap_cnt;  // GAP cycles already completed

  // Every state register holds what is on the line in the current cycle, so
  // each edge decides the next bit from the bit just emitted (hist includes it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GAP;
      gap_cnt    <= '0;
      x_out      <= 1'b0;
      x_en       <= 1'b0;
      ready_out  <= 1'b0;
      frame_done <= 1'b0;
      stuff_cnt  <= '0;
      shreg      <= '0;
      hist       <= '0;
      pre_cnt    <= '0;
      dcnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            shreg     <= data_in;
            hist      <= '0;
            stuff_cnt <= '0;
            pre_cnt   <= '0;
            state     <= PRE;
            x_out     <= 1'b1;
            x_en      <= 1'b1;
            ready_out <= 1'b0;
          end
        end
        PRE: begin
          if (pre_cnt == 2'd3) begin
            state <= DATA;
            x_out <= shreg[DATA_W-1];
            hist  <= {hist[1:0], shreg[DATA_W-1]};
            shreg <= shreg << 1;
            dcnt  <= CW'(1);
          end else begin
            pre_cnt <= pre_cnt + 2'd1;
            // marker is 1,0,1,0: bit k+1 is 1 exactly when k is odd
            x_out   <= pre_cnt[0];
          end
        end
        DATA, STUFF: begin
          if (hist == 3'b101) begin
            // stuffed 1 breaks the 1010 pattern; payload does not advance
            state     <= STUFF;
            x_out     <= 1'b1;
            hist      <= {hist[1:0], 1'b1};
            stuff_cnt <= stuff_cnt + CW'(1);
          end else if (dcnt != CW'(DATA_W)) begin
            state <= DATA;
            x_out <= shreg[DATA_W-1];
            hist  <= {hist[1:0], shreg[DATA_W-1]};
            shreg <= shreg << 1;
            dcnt  <= dcnt + CW'(1);
          end else begin
            state      <= GAP;
            gap_cnt    <= '0;
            x_out      <= 1'b0;
            x_en       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(IDLE_GAP - 1)) begin
            state     <= IDLE;
            ready_out <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_1010_tx.sv
// tb/tb_seq_1010_tx.sv - randomized self-checking bench for seq_1010_tx
module tb_seq_1010_tx;

  localparam int DATA_W   = 8;
  localparam int IDLE_GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, x_out, x_en, frame_done;
  logic [3:0] stuff_cnt;

  seq_1010_tx #(.DATA_W(DATA_W), .IDLE_GAP(IDLE_GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .x_out      (x_out),
    .x_en       (x_en),
    .frame_done (frame_done),
    .stuff_cnt  (stuff_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       x;
    logic       en;
    logic       fd;
    logic       rdy;
    logic       m4;
    logic [3:0] sc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   last_sc = 0;
  bit   chk_en = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   frames = 0;
  int   det_hits = 0;
  int   det_n = 0;
  logic [3:0] det_w = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit list: marker, payload MSB-first, a 1 inserted after every
  // 1,0,1 in the payload region (stuffed bits count toward the history).
  function automatic void gen(input logic [7:0] d, output logic [31:0] bits,
                              output int len, output int sc, output logic [31:0] smask);
    int   h;
    logic b;
    bits = '0; len = 0; sc = 0; smask = '0; h = 0;
    for (int k = 0; k < 4; k++) begin
      bits = {bits[30:0], (k % 2 == 0)};
      len++;
    end
    for (int k = 7; k >= 0; k--) begin
      b = d[k];
      bits = {bits[30:0], b};
      len++;
      h = ((h << 1) | int'(b)) & 7;
      if (h == 5) begin
        bits = {bits[30:0], 1'b1};
        smask[len] = 1'b1;
        len++;
        sc++;
        h = ((h << 1) | 1) & 7;
      end
    end
  endfunction

  function automatic exp_t mk(input logic x, en, fd, rdy, m4, input int sc);
    exp_t e;
    e.x = x; e.en = en; e.fd = fd; e.rdy = rdy; e.m4 = m4; e.sc = 4'(sc);
    return e;
  endfunction

  task automatic push_frame(input logic [7:0] d);
    logic [31:0] bits, smask;
    int len, sc, scs;
    gen(d, bits, len, sc, smask);
    scs = 0;
    for (int i = 0; i < len; i++) begin
      if (smask[i]) scs++;
      q.push_back(mk(bits[len-1-i], 1'b1, 1'b0, 1'b0, (i == 3), scs));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sc));
    for (int i = 1; i < IDLE_GAP; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sc));
    last_sc = sc;
  endtask

  // Reference timeline: what each cycle after this edge must show.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < IDLE_GAP; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      last_sc = 0;
      cur = q.pop_front();
      det_n = 0;
      det_w = '0;
      chk_en = 1'b1;
    end else if (chk_en && cur.rdy && valid_in) begin
      push_frame(data_in);
      frames++;
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, last_sc);
    end
  end

  // Compare, plus a loopback non-overlapping 1010 detector fed by x_out.
  always @(negedge clk) begin
    bit hit;
    if (chk_en) begin
      check("x_out", x_out, cur.x);
      check("x_en", x_en, cur.en);
      check("frame_done", frame_done, cur.fd);
      check("ready_out", ready_out, cur.rdy);
      check("stuff_cnt", stuff_cnt, cur.sc);
      det_w = {det_w[2:0], x_out};
      det_n++;
      hit = (det_n >= 4) && (det_w == 4'b1010);
      if (hit) begin
        det_n = 0;
        det_hits++;
      end
      check("det_z", hit, cur.m4);
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    int n = 0;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", (n < 200), 1);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    if (hold) data_in = 8'($urandom);
    else valid_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bits, smask;
    int len, sc;
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    gen(8'h00, bits, len, sc, smask);
    check("model_00_len", len, 12); check("model_00_bits", bits, 32'b101000000000); check("model_00_sc", sc, 0);
    gen(8'hFF, bits, len, sc, smask);
    check("model_FF_len", len, 12); check("model_FF_bits", bits, 32'b101011111111); check("model_FF_sc", sc, 0);
    gen(8'hAA, bits, len, sc, smask);
    check("model_AA_len", len, 15); check("model_AA_bits", bits, 32'b101010110110110); check("model_AA_sc", sc, 3);
    gen(8'h05, bits, len, sc, smask);
    check("model_05_len", len, 13); check("model_05_bits", bits, 32'b1010000001011); check("model_05_sc", sc, 1);
    gen(8'hA0, bits, len, sc, smask);
    check("model_A0_len", len, 13); check("model_A0_bits", bits, 32'b1010101100000);

    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hAA, 1'b0);
    send(8'h05, 1'b0);

    // reset while payload bit 3 is on the line
    send(8'hC3, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'hA0, 1'b0);

    for (int i = 0; i < 32; i++) send(8'($urandom), 1'b1);
    send(8'hAA, 1'b1);
    send(8'h05, 1'b1);
    send(8'h50, 1'b1);
    send(8'h0A, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    check("det_hits_per_frame", det_hits, frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
